fe_de_fetch_buffer: RTL



---
 rtl/seg_pkg.sv | 16 +
 rtl/fe_de_fetch_buffer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the fetch/decode segment: datapath width, the
// canonical NOP inserted when decode has nothing valid, and the entry format
// carried from fetch to decode.
package seg_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage : seg_pkg

// File: rtl/fe_de_fetch_buffer.sv
// Fetch-to-decode buffer: a small FIFO of {pc, instr} entries with a
// valid/ready handshake toward decode. It replaces a plain IF/ID register.
// fe_enable stalls the fetch PC when the buffer is full, and flush discards
// every buffered entry.
// Optional build macro FE_DE_STALL_CNT_EN adds a saturating counter of the
// cycles in which fetch had a valid instruction but was stalled. Without the
// macro, stall_cnt is tied to zero.
// XLEN is expected to match seg_pkg::XLEN because storage uses fetch_entry_t.
module fe_de_fetch_buffer
  import seg_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = seg_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            fe_valid,
  input  logic [XLEN-1:0] fe_pc,
  input  logic [XLEN-1:0] fe_instr,
  output logic            fe_enable,
  input  logic            de_ready,
  output logic            de_valid,
  output logic [XLEN-1:0] de_pc,
  output logic [XLEN-1:0] de_pc_plus4,
  output logic [XLEN-1:0] de_instr,
  output logic [31:0]     stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t           storage_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   push_s;
  logic                   pop_s;
  fetch_entry_t           head_s;

  // Full/empty are decoded from registered count only, so fe_enable has no
  // combinational path from de_ready. A pop in a full cycle therefore cannot
  // make room for a push in that same cycle.
  assign fe_enable = (count_q != CNT_W'(DEPTH));
  assign de_valid  = (count_q != CNT_W'(0));
  assign push_s    = fe_valid & fe_enable & ~flush;
  assign pop_s     = de_valid & de_ready & ~flush;
  assign head_s    = storage_q[rd_ptr_q];

  // Head presentation: zero PC and NOP when empty so decode sees a bubble.
  always_comb begin
    de_pc    = {XLEN{1'b0}};
    de_instr = XLEN'(NOP_INSTR);
    if (de_valid) begin
      de_pc    = head_s.pc;
      de_instr = head_s.instr;
    end else begin
      de_pc    = {XLEN{1'b0}};
      de_instr = XLEN'(NOP_INSTR);
    end
  end

  assign de_pc_plus4 = de_pc + XLEN'(4);

  // Next-state for pointers and occupancy; flush empties by snapping rd to wr.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = CNT_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: data only, no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      storage_q[wr_ptr_q].pc    <= fe_pc;
      storage_q[wr_ptr_q].instr <= fe_instr;
    end
  end

`ifdef FE_DE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles where fetch had work but was held off;
  // only reset clears it, flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else if (fe_valid && !fe_enable && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule : fe_de_fetch_buffer
